// File: rtl/elm_layer_sequencer_pkg.sv
// Shared state encoding and width helpers for the ELM hidden-layer sequencer.
package elm_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    FEED   = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_e;

  // Width of config_layer_num / config_neuron_num as expected by the neurons.
  function automatic int cfg_num_w(input int dw);
    return 2 * dw + 1;
  endfunction

  // Counters carry one spare bit so they can reach the element count itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elm_layer_sequencer_capture_bank.sv
// Per-neuron activation capture with a completion mask; captures land 1 cycle after outvalid.
// No backpressure: any outvalid while enabled overwrites that neuron's slot.
module elm_capture_bank
  import elm_layer_sequencer_pkg::*;
#(
  parameter int numNeuron = 64,
  parameter int romWidth  = 16,
  localparam int IW       = idx_w(numNeuron)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          cap_en_i,
  input  logic [numNeuron-1:0]          outvalid_i,
  input  logic [numNeuron*romWidth-1:0] data_i,
  input  logic [IW-1:0]                 rd_idx_i,
  output logic                          all_done_o,
  output logic [romWidth-1:0]           rd_data_o
);

  logic [romWidth-1:0]  cap_q [numNeuron];
  logic [numNeuron-1:0] mask_q;

  always_ff @(posedge clk) begin
    // Clear wins over a same-cycle capture so the next vector starts clean.
    if (rst || clear_i) begin
      mask_q <= '0;
    end else if (cap_en_i) begin
      mask_q <= mask_q | outvalid_i;
    end
    for (int i = 0; i < numNeuron; i++) begin
      if (rst) begin
        cap_q[i] <= '0;
      end else if (cap_en_i && outvalid_i[i]) begin
        cap_q[i] <= data_i[i*romWidth +: romWidth];
      end
    end
  end

  assign all_done_o = &mask_q;
  assign rd_data_o  = cap_q[rd_idx_i];

endmodule

// File: rtl/elm_layer_sequencer.sv
// ELM hidden-layer controller: loads weights/biases, broadcasts one input vector, drains activations.
// Neuron strobes are registered (1 cycle after handshake); out_data/out_valid hold while out_ready is low.
module elm_layer_sequencer
  import elm_layer_sequencer_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int romWidth  = 16,
  parameter int numWeight = 128,
  parameter int numNeuron = 64,
  parameter int layerNo   = 1,
  localparam int CFG_W    = cfg_num_w(dataWidth)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [dataWidth-1:0]          cfg_data,
  output logic                          weightValid,
  output logic [dataWidth-1:0]          weightValue,
  output logic [numNeuron-1:0]          biasValid,
  output logic [dataWidth-1:0]          biasValue,
  output logic [CFG_W-1:0]              config_layer_num,
  output logic [CFG_W-1:0]              config_neuron_num,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [dataWidth-1:0]          in_data,
  output logic                          myinputValid,
  output logic [dataWidth-1:0]          myinput,
  input  logic [numNeuron*romWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]          neuron_outvalid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [romWidth-1:0]           out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          loaded
);

  localparam int KW = cnt_w(numWeight);
  localparam int NW = cnt_w(numNeuron);
  localparam int IW = idx_w(numNeuron);

  localparam logic [KW-1:0] K_LAST = KW'(numWeight - 1);
  localparam logic [NW-1:0] N_LAST = NW'(numNeuron - 1);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        d_q, d_d;
  logic                 loaded_q, loaded_d;
  logic                 weight_vld_q, weight_vld_d;
  logic [dataWidth-1:0] weight_dat_q, weight_dat_d;
  logic [numNeuron-1:0] bias_vld_q, bias_vld_d;
  logic [dataWidth-1:0] bias_dat_q, bias_dat_d;
  logic [CFG_W-1:0]     cfg_layer_q, cfg_layer_d;
  logic [CFG_W-1:0]     cfg_neuron_q, cfg_neuron_d;
  logic                 inp_vld_q, inp_vld_d;
  logic [dataWidth-1:0] inp_dat_q, inp_dat_d;

  logic                 cap_clear;
  logic                 cap_en;
  logic                 all_done;
  logic [romWidth-1:0]  rd_data;
  logic                 cfg_hs;
  logic                 in_hs;

  assign cfg_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign in_ready  = (state_q == FEED);
  assign busy      = (state_q != IDLE);
  assign cap_en    = (state_q == FEED) || (state_q == WAIT) || (state_q == DRAIN);
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign in_hs     = in_valid && in_ready;

  assign out_valid = (state_q == DRAIN);
  assign out_data  = (state_q == DRAIN) ? rd_data : '0;
  assign out_last  = (state_q == DRAIN) && (d_q == N_LAST);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    n_d          = n_q;
    d_d          = d_q;
    loaded_d     = loaded_q;
    weight_vld_d = 1'b0;
    weight_dat_d = weight_dat_q;
    bias_vld_d   = '0;
    bias_dat_d   = bias_dat_q;
    cfg_layer_d  = cfg_layer_q;
    cfg_neuron_d = cfg_neuron_q;
    inp_vld_d    = 1'b0;
    inp_dat_d    = inp_dat_q;
    cap_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          loaded_d = 1'b0;
          n_d      = '0;
          k_d      = '0;
          state_d  = LOAD_W;
        end else if (in_valid) begin
          // Only arm the feed here; the first word is taken once in_ready is up.
          k_d     = '0;
          state_d = FEED;
        end
      end
      LOAD_W: begin
        if (cfg_hs) begin
          weight_dat_d = cfg_data;
          weight_vld_d = 1'b1;
          cfg_layer_d  = CFG_W'(layerNo);
          cfg_neuron_d = CFG_W'(n_q);
          k_d          = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (cfg_hs) begin
          bias_dat_d = cfg_data;
          bias_vld_d = numNeuron'(1) << n_q;
          if (n_q == N_LAST) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            n_d     = n_q + 1'b1;
            k_d     = '0;
            state_d = LOAD_W;
          end
        end
      end
      FEED: begin
        if (in_hs) begin
          inp_dat_d = in_data;
          inp_vld_d = 1'b1;
          k_d       = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // all_done is a registered mask, so DRAIN starts after the final capture settles.
        if (all_done) begin
          d_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (d_q == N_LAST) begin
            cap_clear = 1'b1;
            state_d   = IDLE;
          end else begin
            d_d = d_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      n_q          <= '0;
      d_q          <= '0;
      loaded_q     <= 1'b0;
      weight_vld_q <= 1'b0;
      weight_dat_q <= '0;
      bias_vld_q   <= '0;
      bias_dat_q   <= '0;
      cfg_layer_q  <= '0;
      cfg_neuron_q <= '0;
      inp_vld_q    <= 1'b0;
      inp_dat_q    <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      n_q          <= n_d;
      d_q          <= d_d;
      loaded_q     <= loaded_d;
      weight_vld_q <= weight_vld_d;
      weight_dat_q <= weight_dat_d;
      bias_vld_q   <= bias_vld_d;
      bias_dat_q   <= bias_dat_d;
      cfg_layer_q  <= cfg_layer_d;
      cfg_neuron_q <= cfg_neuron_d;
      inp_vld_q    <= inp_vld_d;
      inp_dat_q    <= inp_dat_d;
    end
  end

  assign weightValid       = weight_vld_q;
  assign weightValue       = weight_dat_q;
  assign biasValid         = bias_vld_q;
  assign biasValue         = bias_dat_q;
  assign config_layer_num  = cfg_layer_q;
  assign config_neuron_num = cfg_neuron_q;
  assign myinputValid      = inp_vld_q;
  assign myinput           = inp_dat_q;
  assign loaded            = loaded_q;

  elm_capture_bank #(
    .numNeuron (numNeuron),
    .romWidth  (romWidth)
  ) u_capture_bank (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cap_clear),
    .cap_en_i   (cap_en),
    .outvalid_i (neuron_outvalid),
    .data_i     (neuron_out),
    .rd_idx_i   (d_q[IW-1:0]),
    .all_done_o (all_done),
    .rd_data_o  (rd_data)
  );

endmodule

// File: doc/elm_layer_sequencer.md
Name: elm_layer_sequencer

Overview:
- Controller for one ELM hidden layer built from numNeuron neuron instances.
- Load mode: streams weights and biases into the neurons, addressing each neuron through config_layer_num/config_neuron_num, weightValid and a one-hot biasValid.
- Inference mode: broadcasts one input vector of numWeight words to all neurons and captures each neuron's activation on its outvalid.
- Once all neurons have reported, serializes the activations onto a valid/ready output stream for the output layer.

Parameters:
- dataWidth, 16: width of weight, bias and input words.
- romWidth, 16: width of each neuron activation output.
- numWeight, 128: inputs per neuron, which is also weights per neuron.
- numNeuron, 64: neurons in the layer.
- layerNo, 1: value driven on config_layer_num during load.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  pulse; begins a load sequence (accepted only in IDLE)
- cfg_valid  in  1  load stream valid
- cfg_ready  out  1  load stream ready
- cfg_data  in  dataWidth  load word
- weightValid  out  1  weight strobe to all neurons
- weightValue  out  dataWidth  weight word
- biasValid  out  numNeuron  one-hot bias strobe, bit n drives neuron n
- biasValue  out  dataWidth  bias word
- config_layer_num  out  2*dataWidth+1  target layer
- config_neuron_num  out  2*dataWidth+1  target neuron index
- in_valid  in  1  input vector stream valid
- in_ready  out  1  input vector stream ready
- in_data  in  dataWidth  input word
- myinputValid  out  1  broadcast input strobe
- myinput  out  dataWidth  broadcast input word
- neuron_out  in  numNeuron*romWidth  concatenated activations; neuron n occupies [n*romWidth +: romWidth]
- neuron_outvalid  in  numNeuron  per-neuron outvalid
- out_valid  out  1  activation stream valid
- out_ready  in  1  activation stream ready
- out_data  out  romWidth  activation word
- out_last  out  1  asserted with the word from neuron numNeuron-1
- busy  out  1  high in any state other than IDLE
- loaded  out  1  sticky flag; set when a load completes, cleared by rst or load_start

Behaviour:
- Reset values: all outputs 0, including config_*_num, cfg_ready, in_ready and loaded. State is IDLE, counters are 0, the capture mask is cleared.
- Reset is honoured in every state and aborts the operation immediately.
- Every strobe and data output is registered, so each appears 1 cycle after the accepting handshake.
- Load stream format: for n = 0..numNeuron-1, numWeight weight words followed by 1 bias word.
- FSM states:
  - IDLE:
    - load_start takes priority: clears loaded, sets neuron counter n=0 and word counter k=0, goes to LOAD_W.
    - Otherwise in_valid goes to FEED. in_ready stays 0 in IDLE; no word is consumed on the transition.
  - LOAD_W:
    - cfg_ready=1.
    - Each cfg handshake: weightValue<=cfg_data, weightValid<=1, config_layer_num<=layerNo, config_neuron_num<=n, k++.
    - When k reaches numWeight-1 on a handshake, go to LOAD_B.
  - LOAD_B:
    - cfg_ready=1.
    - On handshake: biasValue<=cfg_data, biasValid<=(1<<n).
    - If n==numNeuron-1: set loaded, go to IDLE. Otherwise n++, k=0, go to LOAD_W.
    - config_neuron_num holds its last value during LOAD_B.
  - FEED:
    - in_ready=1.
    - Each handshake: myinput<=in_data, myinputValid<=1, k++.
    - Gaps in in_valid are allowed; myinputValid drops for the gap.
    - After the numWeight-th handshake: in_ready=0, go to WAIT.
  - WAIT:
    - For every n with neuron_outvalid[n]=1, capture neuron_out slice n into cap[n] and set mask[n].
    - When mask is all ones, go to DRAIN with index d=0. This happens no earlier than the cycle after the final capture.
  - DRAIN:
    - out_valid=1, out_data=cap[d], out_last=(d==numNeuron-1).
    - On out_ready: d++, or, on the last word, clear mask and go to IDLE.
    - out_data and out_valid are stable while out_ready=0.
- neuron_outvalid capture is live in FEED, WAIT and DRAIN. A second outvalid for an already-set mask bit overwrites cap[n]; this is not an error.
- cfg_valid outside load states is ignored, with cfg_ready=0.
- in_valid during load states is ignored, with in_ready=0.
- load_start outside IDLE is ignored.
- weightValid, biasValid and myinputValid are single-cycle pulses per accepted word; all three are never high in the same cycle.
- Counters are sized as $clog2(numWeight)+1 and $clog2(numNeuron)+1 bits. There is no wrap-around inside a sequence.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD_W, LOAD_B, FEED, WAIT, DRAIN);
  - width helper constants: config number width = 2*dataWidth+1, counter widths.
- One sub-module, elm_capture_bank:
  - numNeuron×romWidth capture registers plus the mask;
  - inputs: clear, outvalid vector, concatenated data, read index;
  - outputs: all_done, rd_data.

Test Plan (numNeuron=2, numWeight=4, layerNo=1):
- Load: load_start, then stream 1,2,3,4,B0=9,5,6,7,8,B1=10 with cfg_valid held high.
  - Required: weightValid pulses for 1..4 with config_neuron_num=0 and for 5..8 with config_neuron_num=1.
  - Required: biasValid=2'b01 carrying 9, then 2'b10 carrying 10.
  - Required: loaded=1 after the final word; 10 cycles of cfg_ready=1.
- Feed with gaps: in_data 3,0,1,2 with in_valid low for 1 cycle between words.
  - Required: exactly 4 myinputValid pulses, myinput values in order, in_ready=0 after the 4th.
- Out-of-order completion: neuron_outvalid[1] with data 0x00AA, then 3 cycles later [0] with 0x0055.
  - Required: DRAIN emits 0x0055, then 0x00AA with out_last=1.
- Backpressure: out_ready low for 5 cycles in DRAIN.
  - Required: out_data holds 0x0055 and out_valid stays 1; order is unchanged when out_ready releases.
- Reset mid-FEED after 2 words.
  - Required: next cycle all outputs are 0 and busy=0; a fresh vector is then accepted with k starting at 0.
- Priority: load_start and in_valid both high in IDLE.
  - Required: enters LOAD_W with in_ready=0 and no myinputValid pulse.
- Stray traffic: cfg_valid pulses in IDLE and load_start during FEED.
  - Required: no strobes issued and state unchanged.
